// File: rtl/rvc_fetch_aligner_if.sv
// Handshake bundle between instruction memory, the fetch aligner and decode.
interface rvc_fetch_aligner_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_illegal;

  modport slave (
    input  flush, flush_pc, in_valid, in_word, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_compressed, out_illegal
  );

  modport master (
    output flush, flush_pc, in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_compressed, out_illegal
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// Halfword-buffered fetch aligner with RV32C expansion; one instruction per cycle to decode.
// Define RVC_SP_EN to expand the stack-pointer forms (C.ADDI4SPN, C.ADDI16SP, C.LWSP, C.SWSP).
module rvc_fetch_aligner #(
  parameter int unsigned HW_DEPTH = 8,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  rvc_fetch_aligner_if.slave bus
);
  localparam int unsigned PtrW = $clog2(HW_DEPTH);
  localparam int unsigned CntW = $clog2(HW_DEPTH + 1);

  typedef enum logic [0:0] {StRun, StSkip} state_e;

  logic [15:0]     buf_q [HW_DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] head_p1, head_p2, tail_p1, tail_p2;
  logic [CntW-1:0] count_q, count_d, need, push_amt, pop_amt;
  logic [31:0]     pc_q, pc_d;
  state_e          state_q, state_d;
  logic [15:0]     hw0, hw1;
  logic            is32, valid, push, pop;
  logic [32:0]     exp_c;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(HW_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Returns {illegal, expanded instruction} for a 16-bit parcel.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6;
    logic [20:0] joff;
    logic [12:0] boff;
    r    = '0;
    ill  = 1'b0;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[4:2]};
    rs1p = {2'b01, c[9:7]};
    imm6 = {{7{c[12]}}, c[6:2]};
    joff = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    boff = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
`ifdef RVC_SP_EN
        r   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'b0010011};
        ill = (c[12:5] == 8'h00);
`else
        ill = 1'b1;
`endif
      end
      5'b00_010: r = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'b0000011};
      5'b00_110: r = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000: r = {imm6, rd, 3'b000, rd, 7'b0010011};
      5'b01_001: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'b1101111};
      5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
      5'b01_011: begin
        if (rd == 5'd2) begin
`ifdef RVC_SP_EN
          r   = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'b0010011};
          ill = ({c[12], c[6:2]} == 6'h00);
`else
          ill = 1'b1;
`endif
        end else begin
          r   = {{15{c[12]}}, c[6:2], rd, 7'b0110111};
          ill = ({c[12], c[6:2]} == 6'h00);
        end
      end
      5'b01_100: begin
        unique case (c[11:10])
          2'b00: begin
            r   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
            ill = c[12];
          end
          2'b01: begin
            r   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'b0010011};
            ill = c[12];
          end
          2'b10: r = {imm6, rs1p, 3'b111, rs1p, 7'b0010011};
          default: begin
            ill = c[12];  // RV64 SUBW/ADDW space
            unique case (c[6:5])
              2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'b0110011};
              2'b01:   r = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'b0110011};
              2'b10:   r = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'b0110011};
              default: r = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'b0110011};
            endcase
          end
        endcase
      end
      5'b01_101: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'b1101111};
      5'b01_110: r = {boff[12], boff[10:5], 5'd0, rs1p, 3'b000, boff[4:1], boff[11], 7'b1100011};
      5'b01_111: r = {boff[12], boff[10:5], 5'd0, rs1p, 3'b001, boff[4:1], boff[11], 7'b1100011};
      5'b10_000: begin
        r   = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'b0010011};
        ill = c[12];
      end
      5'b10_010: begin
`ifdef RVC_SP_EN
        r   = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'b0000011};
        ill = (rd == 5'd0);
`else
        ill = 1'b1;
`endif
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            r   = {12'h000, rd, 3'b000, 5'd0, 7'b1100111};
            ill = (rd == 5'd0);
          end else begin
            r = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
          end
        end else if (rs2 == 5'd0) begin
          r = (rd == 5'd0) ? 32'h0010_0073 : {12'h000, rd, 3'b000, 5'd1, 7'b1100111};
        end else begin
          r = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
        end
      end
      5'b10_110: begin
`ifdef RVC_SP_EN
        r = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
`else
        ill = 1'b1;
`endif
      end
      default: ill = 1'b1;  // FP loads/stores and reserved quadrant-0 slot
    endcase
    if (c == 16'h0000) ill = 1'b1;
    if (ill) r = {16'h0000, c};
    return {ill, r};
  endfunction

  assign head_p1 = ptr_inc(head_q);
  assign head_p2 = ptr_inc(head_p1);
  assign tail_p1 = ptr_inc(tail_q);
  assign tail_p2 = ptr_inc(tail_p1);

  assign hw0  = buf_q[head_q];
  assign hw1  = buf_q[head_p1];
  assign is32 = (hw0[1:0] == 2'b11);
  assign need = is32 ? CntW'(2) : CntW'(1);

  assign valid        = (count_q >= need) && !bus.flush;
  assign bus.in_ready = (count_q <= CntW'(HW_DEPTH - 2)) && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = valid && bus.out_ready;
  assign push_amt     = !push ? '0 : (state_q == StSkip) ? CntW'(1) : CntW'(2);
  assign pop_amt      = pop ? need : '0;
  assign exp_c        = expand(hw0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    state_d = state_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = {bus.flush_pc[31:1], 1'b0};
      state_d = bus.flush_pc[1] ? StSkip : StRun;
    end else begin
      if (push) begin
        tail_d  = (state_q == StSkip) ? tail_p1 : tail_p2;
        state_d = StRun;
      end
      if (pop) begin
        head_d = is32 ? head_p2 : head_p1;
        pc_d   = pc_q + (is32 ? 32'd4 : 32'd2);
      end
      count_d = count_q + push_amt - pop_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= PC_RESET;
      state_q <= StRun;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Slot contents need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (state_q == StSkip) begin
        buf_q[tail_q] <= bus.in_word[31:16];
      end else begin
        buf_q[tail_q]  <= bus.in_word[15:0];
        buf_q[tail_p1] <= bus.in_word[31:16];
      end
    end
  end

  always_comb begin
    bus.out_valid      = valid;
    bus.out_pc         = pc_q;
    bus.out_instr      = '0;
    bus.out_compressed = 1'b0;
    bus.out_illegal    = 1'b0;
    if (valid) begin
      if (is32) begin
        bus.out_instr = {hw1, hw0};
      end else begin
        bus.out_instr      = exp_c[31:0];
        bus.out_compressed = 1'b1;
        bus.out_illegal    = exp_c[32];
      end
    end
  end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: directed steps then random traffic against a queue-based model.
module tb_rvc_fetch_aligner;
  localparam int unsigned Depth   = 4;
  localparam logic [31:0] PcReset = 32'h0000_0000;
`ifdef RVC_SP_EN
  localparam bit SpEn = 1'b1;
`else
  localparam bit SpEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvc_fetch_aligner_if bus ();

  rvc_fetch_aligner #(
    .HW_DEPTH(Depth),
    .PC_RESET(PcReset)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [15:0] mq [$];
  logic [31:0] m_pc;
  bit          m_skip;
  logic        e_valid, e_ready;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic int fld(input logic [15:0] h, input int hi, input int lo);
    return int'((h >> lo) & ((1 << (hi - lo + 1)) - 1));
  endfunction

  function automatic int sx(input int v, input int n);
    return (v >= (1 << (n - 1))) ? v - (1 << n) : v;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input int op);
    logic [31:0] u;
    u = imm;
    return ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] u;
    u = imm;
    return (((u >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
         | ((u & 32'h1f) << 7) | 32'h23;
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int f3);
    logic [31:0] u;
    u = imm;
    return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(rs1) << 15)
         | (32'(f3) << 12) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] u;
    u = imm;
    return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21)
         | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'h6f;
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
         | (32'(rd) << 7) | 32'h33;
  endfunction

  function automatic logic [31:0] enc_u(input int imm, input int rd);
    logic [31:0] u;
    u = imm;
    return ((u & 32'hfffff) << 12) | (32'(rd) << 7) | 32'h37;
  endfunction

  // Reference RV32C expansion from the ISA rules: {illegal, instruction}.
  function automatic logic [32:0] ref_expand(input logic [15:0] h);
    int quad, f3, rd, rs2, rdp, rs1p, imm6, off;
    int alu_f3 [4];
    logic [31:0] r;
    bit ill;
    alu_f3 = '{0, 4, 6, 7};
    quad = fld(h, 1, 0);
    f3   = fld(h, 15, 13);
    rd   = fld(h, 11, 7);
    rs2  = fld(h, 6, 2);
    rdp  = 8 + fld(h, 4, 2);
    rs1p = 8 + fld(h, 9, 7);
    imm6 = sx(fld(h, 12, 12) * 32 + fld(h, 6, 2), 6);
    r    = 0;
    ill  = 0;
    if (quad == 0) begin
      if (f3 == 0) begin
        off = fld(h, 10, 7) * 64 + fld(h, 12, 11) * 16 + fld(h, 5, 5) * 8 + fld(h, 6, 6) * 4;
        ill = !SpEn || off == 0;
        r   = enc_i(off, 2, 0, rdp, 'h13);
      end else if (f3 == 2 || f3 == 6) begin
        off = fld(h, 5, 5) * 64 + fld(h, 12, 10) * 8 + fld(h, 6, 6) * 4;
        r   = (f3 == 2) ? enc_i(off, rs1p, 2, rdp, 'h03) : enc_s(off, rdp, rs1p, 2);
      end else begin
        ill = 1;
      end
    end else if (quad == 1) begin
      case (f3)
        0: r = enc_i(imm6, rd, 0, rd, 'h13);
        1, 5: begin
          off = sx(fld(h, 12, 12) * 2048 + fld(h, 8, 8) * 1024 + fld(h, 10, 9) * 256
                   + fld(h, 6, 6) * 128 + fld(h, 7, 7) * 64 + fld(h, 2, 2) * 32
                   + fld(h, 11, 11) * 16 + fld(h, 5, 3) * 2, 12);
          r = enc_j(off, (f3 == 1) ? 1 : 0);
        end
        2: r = enc_i(imm6, 0, 0, rd, 'h13);
        3: begin
          if (rd == 2) begin
            off = sx(fld(h, 12, 12) * 512 + fld(h, 4, 3) * 128 + fld(h, 5, 5) * 64
                     + fld(h, 2, 2) * 32 + fld(h, 6, 6) * 16, 10);
            ill = !SpEn || off == 0;
            r   = enc_i(off, 2, 0, 2, 'h13);
          end else begin
            ill = imm6 == 0;
            r   = enc_u(imm6, rd);
          end
        end
        4: begin
          case (fld(h, 11, 10))
            0, 1: begin
              ill = fld(h, 12, 12) != 0;
              r   = enc_i(fld(h, 6, 2) + fld(h, 10, 10) * 1024, rs1p, 5, rs1p, 'h13);
            end
            2: r = enc_i(imm6, rs1p, 7, rs1p, 'h13);
            default: begin
              ill = fld(h, 12, 12) != 0;
              r   = enc_r((fld(h, 6, 5) == 0) ? 32 : 0, rdp, rs1p, alu_f3[fld(h, 6, 5)], rs1p);
            end
          endcase
        end
        default: begin
          off = sx(fld(h, 12, 12) * 256 + fld(h, 6, 5) * 64 + fld(h, 2, 2) * 32
                   + fld(h, 11, 10) * 8 + fld(h, 4, 3) * 2, 9);
          r   = enc_b(off, rs1p, (f3 == 6) ? 0 : 1);
        end
      endcase
    end else begin
      case (f3)
        0: begin
          ill = fld(h, 12, 12) != 0;
          r   = enc_i(rs2, rd, 1, rd, 'h13);
        end
        2: begin
          off = fld(h, 3, 2) * 64 + fld(h, 12, 12) * 32 + fld(h, 6, 4) * 4;
          ill = !SpEn || rd == 0;
          r   = enc_i(off, 2, 2, rd, 'h03);
        end
        4: begin
          if (fld(h, 12, 12) == 0) begin
            if (rs2 == 0) begin
              ill = rd == 0;
              r   = enc_i(0, rd, 0, 0, 'h67);
            end else begin
              r = enc_r(0, rs2, 0, 0, rd);
            end
          end else if (rs2 == 0) begin
            r = (rd == 0) ? 32'h0010_0073 : enc_i(0, rd, 0, 1, 'h67);
          end else begin
            r = enc_r(0, rs2, rd, 0, rd);
          end
        end
        6: begin
          off = fld(h, 8, 7) * 64 + fld(h, 12, 9) * 4;
          ill = !SpEn;
          r   = enc_s(off, rs2, 2, 2);
        end
        default: ill = 1;
      endcase
    end
    if (h == 16'h0000) ill = 1;
    if (ill) r = {16'h0000, h};
    return {ill, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_check();
    int          need;
    logic [32:0] x;
    e_ready = (mq.size() <= int'(Depth) - 2) && !bus.flush;
    need    = 0;
    if (mq.size() > 0) need = (mq[0][1:0] == 2'b11) ? 2 : 1;
    e_valid = (need != 0) && (mq.size() >= need) && !bus.flush;
    chk("in_ready", 32'(bus.in_ready), 32'(e_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    chk("out_pc", bus.out_pc, m_pc);
    if (e_valid) begin
      if (need == 2) begin
        chk("instr32", bus.out_instr, {mq[1], mq[0]});
        chk("comp32", 32'(bus.out_compressed), 32'd0);
        chk("ill32", 32'(bus.out_illegal), 32'd0);
      end else begin
        x = ref_expand(mq[0]);
        chk("instr16", bus.out_instr, x[31:0]);
        chk("comp16", 32'(bus.out_compressed), 32'd1);
        chk("ill16", 32'(bus.out_illegal), 32'(x[32]));
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      mq.delete();
      m_pc   = PcReset;
      m_skip = 0;
    end else if (bus.flush) begin
      mq.delete();
      m_pc   = {bus.flush_pc[31:1], 1'b0};
      m_skip = bus.flush_pc[1];
    end else begin
      if (e_valid && bus.out_ready) begin
        if (mq[0][1:0] == 2'b11) begin
          void'(mq.pop_front());
          void'(mq.pop_front());
          m_pc += 32'd4;
        end else begin
          void'(mq.pop_front());
          m_pc += 32'd2;
        end
      end
      if (bus.in_valid && e_ready) begin
        if (!m_skip) mq.push_back(bus.in_word[15:0]);
        mq.push_back(bus.in_word[31:16]);
        m_skip = 0;
      end
    end
  endtask

  // Inputs are set just after a rising edge; checks land 1ns later, mid-cycle.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    do_reset();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_pc", bus.out_pc, PcReset);

    // C.J followed by an all-zero (illegal) parcel
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0000_A001;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("cj_instr", bus.out_instr, 32'h0000_006F);
    chk("cj_comp", 32'(bus.out_compressed), 32'd1);
    step();
    #1;
    chk("zero_ill", 32'(bus.out_illegal), 32'd1);
    chk("zero_pc", bus.out_pc, 32'd2);
    step();

    // 32-bit instruction straddling two fetch words
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0513_157D;
    step();
    bus.in_word = 32'h4398_FFF5;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("addi_instr", bus.out_instr, 32'hFFF5_0513);
    step();
    #1;
    chk("span_instr", bus.out_instr, 32'hFFF5_0513);
    chk("span_pc", bus.out_pc, 32'd2);
    chk("span_comp", 32'(bus.out_compressed), 32'd0);
    step();
    #1;
    chk("lw_instr", bus.out_instr, 32'h0007_A703);
    chk("lw_pc", bus.out_pc, 32'd6);
    step();

    // Flush to a halfword target discards the low half of the next word
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0001_0001;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h0000_0102;
    #1;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h4398_157D;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("skip_instr", bus.out_instr, 32'h0007_A703);
    chk("skip_pc", bus.out_pc, 32'h0000_0102);
    step();

    // Backpressure: buffer fills and holds its head stable
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0001_0001;
    step();
    step();
    #1;
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    step();
    step();
    #1;
    chk("full_hold", bus.out_instr, 32'h0000_0013);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // C.LWSP, gated by the stack-pointer option
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_word  = 32'h0000_4502;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("lwsp_instr", bus.out_instr, SpEn ? 32'h0001_2503 : 32'h0000_4502);
    chk("lwsp_ill", 32'(bus.out_illegal), 32'(!SpEn));
    step();
    step();

    // Reset with three halfwords buffered
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    bus.flush_pc  = 32'h0000_0002;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word  = 32'h0001_0001;
    step();
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_pc", bus.out_pc, PcReset);

    // PC wraps modulo 2^32
    bus.flush    = 1'b1;
    bus.flush_pc = 32'hFFFF_FFFD;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_word   = 32'h0001_0001;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    #1;
    chk("pc_wrap", bus.out_pc, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.flush_pc  = $urandom;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_word   = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
